// File: rtl/uart_defs.sv
// uart_defs: shared receiver state encodings and frame constants
package uart_defs;
   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} rx_state_t;
   localparam int FRAME_BITS = 8;
   localparam int DEF_CLKS_PER_BIT = 868;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; head is shown combinationally
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty = wr_ptr == rd_ptr;
   assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop = pop & ~empty;
   // a pop frees the slot, so a push into a full FIFO still lands when paired with one
   assign do_push = push & (~full | do_pop);
   assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/uart_rx_intc.sv
// uart_rx_intc: 8N1 UART receiver with byte FIFO, sticky error flags and level interrupt
module uart_rx_intc
   import uart_defs::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  RX,
   input  logic                  IE,
   input  logic                  RD_EN,
   output logic [FRAME_BITS-1:0] RD_DATA,
   output logic                  RD_VALID,
   output logic                  FRAME_ERR,
   output logic                  OVERRUN,
   input  logic                  ERR_CLR,
   output logic                  INTERRUPT
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   rx_state_t state, next;
   logic rx_q, rx_s;
   logic [CW-1:0] cnt;
   logic [2:0] bit_cnt;
   logic [FRAME_BITS-1:0] shreg;
   logic sample, push, ferr_set, full, empty, ovf;
   always_comb begin
      next = state;
      sample = 1'b0;
      push = 1'b0;
      ferr_set = 1'b0;
      case (state)
         IDLE:  next = rx_s ? IDLE : START;
         START: if (cnt == HALF) next = rx_s ? IDLE : DATA;
         DATA:
            if (cnt == LAST) begin
               sample = 1'b1;
               next = (bit_cnt == 3'd7) ? STOP : DATA;
            end
         STOP:
            if (cnt == LAST) begin
               next = IDLE;
               push = rx_s;
               ferr_set = ~rx_s;
            end
         default: next = IDLE;
      endcase
   end
   assign ovf = push & full & ~RD_EN;
   assign RD_VALID = ~empty;
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         rx_q <= 1'b1;
         rx_s <= 1'b1;
         state <= IDLE;
         cnt <= '0;
         bit_cnt <= '0;
         shreg <= '0;
         FRAME_ERR <= 1'b0;
         OVERRUN <= 1'b0;
         INTERRUPT <= 1'b0;
      end else begin
         rx_q <= RX;
         rx_s <= rx_q;
         state <= next;
         cnt <= (state != next) ? '0 : cnt + 1'b1;
         if (sample) begin
            shreg <= {rx_s, shreg[FRAME_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
         end
         // a set event in the same cycle as a clear takes priority
         FRAME_ERR <= ferr_set | (FRAME_ERR & ~ERR_CLR);
         OVERRUN <= ovf | (OVERRUN & ~ERR_CLR);
         INTERRUPT <= IE & (RD_VALID | FRAME_ERR | OVERRUN);
      end
   end
   sync_fifo #(.WIDTH(FRAME_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (CLK),
      .rst_n     (RESET),
      .push      (push),
      .push_data (shreg),
      .pop       (RD_EN),
      .head      (RD_DATA),
      .full      (full),
      .empty     (empty)
   );
endmodule

// File: tb/tb_uart_rx_intc.sv
// tb_uart_rx_intc: scoreboard bench with a queue-based receiver model and random frames
module tb_uart_rx_intc;
   localparam int CPB = 16;
   localparam int DEPTH = 4;
   localparam int PUSH_NEG = 9 * CPB + CPB / 2 + 2;
   logic clk = 1'b0, reset = 1'b0, rx = 1'b1, ie = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
   logic [7:0] rd_data;
   logic rd_valid, frame_err, overrun, interrupt;
   int n_chk = 0, n_fail = 0;
   byte unsigned model_q[$], exp_q[$];
   bit m_ferr = 1'b0, m_ovr = 1'b0;
   uart_rx_intc #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .CLK       (clk),
      .RESET     (reset),
      .RX        (rx),
      .IE        (ie),
      .RD_EN     (rd_en),
      .RD_DATA   (rd_data),
      .RD_VALID  (rd_valid),
      .FRAME_ERR (frame_err),
      .OVERRUN   (overrun),
      .ERR_CLR   (err_clr),
      .INTERRUPT (interrupt)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic check_state(input string tag);
      repeat (2) @(negedge clk);
      #1;
      chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) chk({tag, ".rd_data"}, 32'(rd_data), 32'(model_q[0]));
      chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
      chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
      chk({tag, ".interrupt"}, 32'(interrupt), 32'(ie & ((model_q.size() != 0) | m_ferr | m_ovr)));
   endtask
   // monitor: every accepted pop is compared with the scoreboard head
   initial forever begin
      @(negedge clk);
      #1;
      if (rd_en) begin
         if (rd_valid && exp_q.size() == 0) chk("sb.unexpected_pop", 32'(rd_valid), 32'(0));
         else if (rd_valid) chk("sb.pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
         else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            chk("sb.pop_valid", 32'(rd_valid), 32'(1));
         end
      end
   end
   task automatic pop_one();
      @(negedge clk);
      rd_en = 1'b1;
      if (model_q.size() != 0) exp_q.push_back(model_q.pop_front());
      @(negedge clk);
      rd_en = 1'b0;
   endtask
   task automatic clr_err();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      m_ferr = 1'b0;
      m_ovr = 1'b0;
   endtask
   // mode 1: pop on the push cycle; mode 2: check byte/interrupt latency around the push
   task automatic send_frame(input byte unsigned b, input bit stop, input int mode);
      logic [9:0] bits;
      bits = {stop, b, 1'b0};
      @(negedge clk);
      fork
         for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (CPB) @(negedge clk);
         end
         begin
            if (mode == 1) begin
               repeat (PUSH_NEG) @(negedge clk);
               rd_en = 1'b1;
               if (model_q.size() != 0) exp_q.push_back(model_q.pop_front());
               @(negedge clk);
               rd_en = 1'b0;
            end
            if (mode == 2) begin
               repeat (PUSH_NEG) @(negedge clk);
               #1 chk("lat.valid_before", 32'(rd_valid), 32'(0));
               @(negedge clk);
               #1;
               chk("lat.valid_after", 32'(rd_valid), 32'(1));
               chk("lat.data", 32'(rd_data), 32'(b));
               chk("lat.irq_lag", 32'(interrupt), 32'(0));
               @(negedge clk);
               #1 chk("lat.irq", 32'(interrupt), 32'(1));
            end
         end
      join
      rx = 1'b1;
      repeat (20) @(negedge clk);
      if (!stop) m_ferr = 1'b1;
      else if (model_q.size() < DEPTH) model_q.push_back(b);
      else m_ovr = 1'b1;
   endtask
   initial begin
      repeat (3) @(negedge clk);
      #1;
      chk("rst.rd_valid", 32'(rd_valid), 32'(0));
      chk("rst.rd_data", 32'(rd_data), 32'(0));
      chk("rst.frame_err", 32'(frame_err), 32'(0));
      chk("rst.overrun", 32'(overrun), 32'(0));
      chk("rst.interrupt", 32'(interrupt), 32'(0));
      reset = 1'b1;
      ie = 1'b1;
      send_frame(8'hA5, 1'b1, 2);
      check_state("a5");
      pop_one();
      #1;
      chk("a5.empty_after_pop", 32'(rd_valid), 32'(0));
      chk("a5.irq_still", 32'(interrupt), 32'(1));
      @(negedge clk);
      #1 chk("a5.irq_drop", 32'(interrupt), 32'(0));
      @(negedge clk);
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check_state("glitch");
      send_frame(8'h3C, 1'b0, 0);
      check_state("ferr");
      clr_err();
      #1;
      chk("ferr.cleared", 32'(frame_err), 32'(0));
      chk("ferr.irq_still", 32'(interrupt), 32'(1));
      @(negedge clk);
      #1 chk("ferr.irq_drop", 32'(interrupt), 32'(0));
      for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, 0);
      check_state("ovr");
      repeat (4) pop_one();
      check_state("ovr_drain");
      clr_err();
      for (int v = 1; v <= 4; v++) send_frame(8'(v), 1'b1, 0);
      send_frame(8'h55, 1'b1, 1);
      check_state("simul");
      repeat (4) pop_one();
      check_state("simul_drain");
      send_frame(8'h77, 1'b1, 0);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      model_q.delete();
      m_ferr = 1'b0;
      m_ovr = 1'b0;
      check_state("midrst");
      chk("midrst.rd_data", 32'(rd_data), 32'(0));
      send_frame(8'h12, 1'b1, 0);
      check_state("post_rst");
      pop_one();
      for (int n = 0; n < 16; n++) begin
         ie = 1'($urandom_range(0, 1));
         send_frame(8'($urandom), $urandom_range(0, 7) != 0, 0);
         check_state("rnd_rx");
         repeat ($urandom_range(0, 3)) pop_one();
         if ($urandom_range(0, 3) == 0) clr_err();
         check_state("rnd_pop");
      end
      while (model_q.size() != 0) pop_one();
      repeat (3) @(negedge clk);
      chk("sb.all_seen", 32'(exp_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
